// File: rtl/pwm_sequencer.sv
// PWM sequencer: debounced rate select applied only at period boundaries, plus a triangular duty ramp.
// Optional peak/valley hold is enabled by defining SEQ_HOLD_EN.
module pwm_sequencer #(
    parameter int CNT_W        = 4,
    parameter int DUTY_STEP    = 4,
    parameter int DEB_LEN      = 3,
    parameter int HOLD_PERIODS = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sw0,
    input  logic             en,
    input  logic             freq_trig_in,
    output logic             sel_o,
    output logic             pwm_o,
    output logic [CNT_W-1:0] duty_o,
    output logic             period_end_o,
    output logic [1:0]       state_o
);

    localparam logic [CNT_W-1:0] MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STEP     = CNT_W'(DUTY_STEP);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(DUTY_STEP);
    localparam int               DEB_W    = $clog2(DEB_LEN + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_LEN - 1);

    if (DEB_LEN < 1 || HOLD_PERIODS < 1 || DUTY_STEP < 1 || DUTY_STEP > (2**CNT_W) - 1) begin : g_bad_params
        $error("pwm_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
`ifdef SEQ_HOLD_EN
        , S_HOLD = 2'd3
`endif
    } state_t;

    logic [1:0]       sync_reg;
    logic             sw_db_reg;
    logic [DEB_W-1:0] deb_cnt_reg;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] duty_reg, duty_next;
    logic             sel_reg, sel_next;
    logic             pwm_reg, pwm_next;
    logic             pend_reg, pend_next;
    logic [CNT_W:0]   up_sum;
    logic             wrap;

`ifdef SEQ_HOLD_EN
    localparam int               HOLD_W    = $clog2(HOLD_PERIODS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    state_t            dir_reg, dir_next;
`endif

    // Switch only counts as changed once the synchronised level has differed for DEB_LEN cycles.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_reg    <= '0;
            sw_db_reg   <= 1'b0;
            deb_cnt_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], sw0};
            if (sync_reg[1] == sw_db_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                sw_db_reg   <= sync_reg[1];
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            duty_reg     <= '0;
            sel_reg      <= 1'b0;
            pwm_reg      <= 1'b0;
            pend_reg     <= 1'b0;
`ifdef SEQ_HOLD_EN
            hold_cnt_reg <= '0;
            dir_reg      <= S_IDLE;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            duty_reg     <= duty_next;
            sel_reg      <= sel_next;
            pwm_reg      <= pwm_next;
            pend_reg     <= pend_next;
`ifdef SEQ_HOLD_EN
            hold_cnt_reg <= hold_cnt_next;
            dir_reg      <= dir_next;
`endif
        end
    end

    assign up_sum = {1'b0, duty_reg} + STEP_X;
    assign wrap   = freq_trig_in && (cnt_reg == MAX);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        duty_next  = duty_reg;
        sel_next   = sel_reg;
        pwm_next   = 1'b0;
        pend_next  = 1'b0;
`ifdef SEQ_HOLD_EN
        hold_cnt_next = hold_cnt_reg;
        dir_next      = dir_reg;
`endif
        // A pending rate change is only released at a period boundary so no period mixes rates.
        if (state_reg == S_IDLE || pend_reg) begin
            sel_next = sw_db_reg;
        end

        if (!en) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            duty_next  = '0;
`ifdef SEQ_HOLD_EN
            hold_cnt_next = '0;
`endif
        end else if (state_reg == S_IDLE) begin
            state_next = S_UP;
            cnt_next   = '0;
            duty_next  = '0;
        end else begin
            pwm_next  = (cnt_reg < duty_reg);
            pend_next = wrap;
            if (freq_trig_in) begin
                cnt_next = cnt_reg + 1'b1;
            end
            if (wrap) begin
                case (state_reg)
                    S_UP: begin
                        if (up_sum >= {1'b0, MAX}) begin
                            duty_next = MAX;
`ifdef SEQ_HOLD_EN
                            state_next = S_HOLD;
                            dir_next   = S_DOWN;
`else
                            state_next = S_DOWN;
`endif
                        end else begin
                            duty_next = up_sum[CNT_W-1:0];
                        end
                    end
                    S_DOWN: begin
                        if (duty_reg <= STEP) begin
                            duty_next = '0;
`ifdef SEQ_HOLD_EN
                            state_next = S_HOLD;
                            dir_next   = S_UP;
`else
                            state_next = S_UP;
`endif
                        end else begin
                            duty_next = duty_reg - STEP;
                        end
                    end
`ifdef SEQ_HOLD_EN
                    S_HOLD: begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_next    = dir_reg;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + 1'b1;
                        end
                    end
`endif
                    default: state_next = S_IDLE;
                endcase
            end
        end
    end

    assign sel_o        = sel_reg;
    assign pwm_o        = pwm_reg;
    assign duty_o       = duty_reg;
    assign period_end_o = pend_reg;
    assign state_o      = state_reg;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed self-checking bench for pwm_sequencer; expectations follow the SEQ_HOLD_EN build setting.
module tb_pwm_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_in, sw0, en, freq_trig_in;
    logic       sel_o, pwm_o, period_end_o;
    logic [3:0] duty_o;
    logic [1:0] state_o;

    int tests = 0;
    int fails = 0;
    bit trig_auto = 1'b0;
    bit trig_phase = 1'b0;

`ifdef SEQ_HOLD_EN
    localparam int NW = 13;
    int exp_duty[NW]  = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0, 0, 0, 4};
    int exp_state[NW] = '{1, 1, 1, 3, 3, 2, 2, 2, 2, 3, 3, 1, 1};
`else
    localparam int NW = 9;
    int exp_duty[NW]  = '{4, 8, 12, 15, 11, 7, 3, 0, 4};
    int exp_state[NW] = '{1, 1, 1, 2, 2, 2, 2, 1, 1};
`endif

    pwm_sequencer dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sw0          (sw0),
        .en           (en),
        .freq_trig_in (freq_trig_in),
        .sel_o        (sel_o),
        .pwm_o        (pwm_o),
        .duty_o       (duty_o),
        .period_end_o (period_end_o),
        .state_o      (state_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk_in);
        if (trig_auto) begin
            trig_phase   = ~trig_phase;
            freq_trig_in = trig_phase;
        end else begin
            freq_trig_in = 1'b0;
        end
    endtask

    task automatic wait_pe(output int cycles, output int highs, output bit ok);
        cycles = 0;
        highs  = 0;
        ok     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            cycles++;
            if (period_end_o) begin
                ok = 1'b1;
                break;
            end
            highs += int'(pwm_o);
        end
    endtask

    task automatic wait_duty(input int d, output bit ok);
        int  c, h;
        bit  got;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            wait_pe(c, h, got);
            if (!got) break;
            if (int'(duty_o) == d) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  c, h, n_pe, n_pwm, n_duty, n_state, n_sel_low;
        bit  ok;

        rst_in = 1'b1; sw0 = 1'b0; en = 1'b0; freq_trig_in = 1'b0;
        repeat (3) cyc();
        check("rst_state", state_o, 0);
        check("rst_duty", duty_o, 0);
        check("rst_pwm", pwm_o, 0);
        check("rst_pe", period_end_o, 0);
        check("rst_sel", sel_o, 0);
        $display("[TB] reset: state=%0d duty=%0d pwm=%0d", state_o, duty_o, pwm_o);

        // Disabled: triggers must be ignored.
        rst_in = 1'b0;
        trig_auto = 1'b1;
        n_pe = 0; n_pwm = 0; n_duty = 0; n_state = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n_pe    += int'(period_end_o);
            n_pwm   += int'(pwm_o);
            n_duty  += (duty_o != 4'd0) ? 1 : 0;
            n_state += (state_o != 2'd0) ? 1 : 0;
        end
        check("t1_pe_pulses", n_pe, 0);
        check("t1_pwm_high", n_pwm, 0);
        check("t1_duty_nonzero", n_duty, 0);
        check("t1_state_nonidle", n_state, 0);
        $display("[TB] idle run: pe=%0d pwm=%0d", n_pe, n_pwm);

        // Ramp: duty, state, period length and pwm high time per wrap.
        en = 1'b1;
        cyc();
        check("t2_start_state", state_o, 1);
        check("t2_start_duty", duty_o, 0);
        wait_pe(c, h, ok);
        check("t2_first_wrap", ok, 1);
        for (int k = 0; k < NW; k++) begin
            check($sformatf("t2_duty_%0d", k), duty_o, exp_duty[k]);
            check($sformatf("t2_state_%0d", k), state_o, exp_state[k]);
            if (k < NW - 1) begin
                wait_pe(c, h, ok);
                check($sformatf("t2_wrap_%0d", k), ok, 1);
                check($sformatf("t2_period_%0d", k), c, 32);
                check($sformatf("t2_pwm_high_%0d", k), h, 2 * exp_duty[k]);
                $display("[TB] wrap %0d: duty=%0d state=%0d period=%0d high=%0d", k, exp_duty[k], exp_state[k], c, h);
            end
        end

        // Rate select change mid-period waits for the boundary.
        repeat (10) cyc();
        sw0 = 1'b1;
        repeat (10) cyc();
        check("t3_sel_waits", sel_o, 0);
        wait_pe(c, h, ok);
        check("t3_wrap", ok, 1);
        check("t3_sel_at_pe", sel_o, 0);
        check("t3_duty", duty_o, 8);
        cyc();
        check("t3_sel_after_pe", sel_o, 1);
        $display("[TB] sel change applied at boundary: sel=%0d", sel_o);
        repeat (5) cyc();
        sw0 = 1'b0;
        cyc();
        cyc();
        sw0 = 1'b1;
        n_sel_low = 0; n_pe = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n_sel_low += (sel_o == 1'b0) ? 1 : 0;
            n_pe      += int'(period_end_o);
        end
        check("t3_glitch_sel", n_sel_low, 0);
        check("t3_glitch_window_pe", n_pe, 1);
        $display("[TB] glitch: sel low cycles=%0d", n_sel_low);

        // Disable coinciding with the wrap out of duty 12.
        wait_duty(12, ok);
        check("t4_reach_12", ok, 1);
        repeat (31) cyc();
        check("t4_no_early_pe", period_end_o, 0);
        en = 1'b0;
        cyc();
        check("t4_state", state_o, 0);
        check("t4_duty", duty_o, 0);
        check("t4_pwm", pwm_o, 0);
        check("t4_pe", period_end_o, 0);
        check("t4_sel_before", sel_o, 1);
        sw0 = 1'b0;
        repeat (4) cyc();
        check("t4_sel_debouncing", sel_o, 1);
        repeat (4) cyc();
        check("t4_sel_idle_follow", sel_o, 0);
        en = 1'b1;
        cyc();
        check("t4_reen_state", state_o, 1);
        check("t4_reen_duty", duty_o, 0);
        wait_pe(c, h, ok);
        check("t4_reen_wrap", ok, 1);
        check("t4_reen_first_duty", duty_o, 4);
        $display("[TB] disable at wrap and re-enable: duty=%0d", duty_o);

        // Asynchronous reset in DOWN at duty 7.
        sw0 = 1'b1;
        wait_duty(7, ok);
        check("t5_reach_7", ok, 1);
        check("t5_state_down", state_o, 2);
        repeat (5) cyc();
        check("t5_pwm_pre", pwm_o, 1);
        check("t5_sel_pre", sel_o, 1);
        #2 rst_in = 1'b1;
        #1;
        check("t5_state", state_o, 0);
        check("t5_duty", duty_o, 0);
        check("t5_pwm", pwm_o, 0);
        check("t5_pe", period_end_o, 0);
        check("t5_sel", sel_o, 0);
        cyc();
        en = 1'b0;
        rst_in = 1'b0;
        cyc();
        check("t5_idle_after_release", state_o, 0);
        $display("[TB] async reset: state=%0d duty=%0d", state_o, duty_o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
